// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_byte_rx
// Brief   : 8N1 UART byte receiver with mid-bit sampling, one-byte holding
//           register, frame-error pulse and sticky overrun flag.
// Revision: 1.0 - initial release
// ============================================================================
module uart_byte_rx #(
  parameter int CNT = 109
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       data_ready,
  input  logic       overrun_clr,
  output logic [7:0] RX,
  output logic       rx_valid,
  output logic       rx_byte_stop,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_start = 2'd1;
  localparam logic [1:0] c_data  = 2'd2;
  localparam logic [1:0] c_stop  = 2'd3;

  localparam logic [15:0] c_half_cnt = 16'((CNT - 1) / 2);
  localparam logic [15:0] c_last_cnt = 16'(CNT - 1);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync_d;
  logic [1:0]  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_wait_high;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_byte_stop;
  logic        r_frame_err;
  logic        r_overrun;

  logic w_fall;
  logic w_tick_half;
  logic w_tick_bit;
  logic w_stop_sample;
  logic w_good;
  logic w_bad;
  logic w_overrun_set;

  assign w_fall        = r_sync_d & ~r_sync2;
  assign w_tick_half   = (r_cnt == c_half_cnt);
  assign w_tick_bit    = (r_cnt == c_last_cnt);
  assign w_stop_sample = (r_state == c_stop) && !r_wait_high && w_tick_bit;
  assign w_good        = w_stop_sample && r_sync2;
  assign w_bad         = w_stop_sample && !r_sync2;
  assign w_overrun_set = w_good && r_rx_valid && !data_ready;

  // Synchronizer flops reset high so reset release never looks like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= rx;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_idle;
      r_cnt       <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_wait_high <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          r_wait_high <= 1'b0;
          if (w_fall) begin
            r_state <= c_start;
            r_cnt   <= 16'd0;
          end
        end
        c_start: begin
          if (w_tick_half) begin
            r_cnt <= 16'd0;
            if (!r_sync2) begin
              r_state   <= c_data;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= c_idle;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        c_data: begin
          if (w_tick_bit) begin
            r_cnt              <= 16'd0;
            r_shift[r_bit_idx] <= r_sync2;
            r_bit_idx          <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= c_stop;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        c_stop: begin
          // After a bad stop bit, park here until the line idles high again
          if (r_wait_high) begin
            if (r_sync2) begin
              r_state     <= c_idle;
              r_wait_high <= 1'b0;
            end
          end else if (w_tick_bit) begin
            r_cnt <= 16'd0;
            if (r_sync2) begin
              r_state <= c_idle;
            end else begin
              r_wait_high <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_byte_stop <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_byte_stop <= w_good;
      r_frame_err <= w_bad;
      // A new byte replaces the held one only if the held one is consumed now
      if (w_good && !w_overrun_set) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && data_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign RX           = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_byte_stop = r_byte_stop;
  assign frame_err    = r_frame_err;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_byte_rx
// Brief   : Directed bench for uart_byte_rx with an expected-byte scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_byte_rx;

  localparam int CNT = 109;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       data_ready;
  logic       overrun_clr;
  logic [7:0] RX;
  logic       rx_valid;
  logic       rx_byte_stop;
  logic       frame_err;
  logic       overrun;

  int         checks;
  int         errors;
  int         n_stop;
  int         n_ferr;
  logic       prev_stop;
  logic       prev_ferr;
  logic [7:0] sb_q[$];
  logic [7:0] exp_byte;

  uart_byte_rx #(.CNT(CNT)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .data_ready   (data_ready),
    .overrun_clr  (overrun_clr),
    .RX           (RX),
    .rx_valid     (rx_valid),
    .rx_byte_stop (rx_byte_stop),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_period(input logic v);
    rx = v;
    wait_cycles(CNT);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
    bit_period(stop_bit);
    rx = 1'b1;
  endtask

  // Output monitor: pops the scoreboard on each good-frame pulse
  always @(negedge clk) begin
    if (rst) begin
      prev_stop = 1'b0;
      prev_ferr = 1'b0;
    end else begin
      if (rx_byte_stop) begin
        n_stop++;
        checks++;
        assert (sb_q.size() > 0) else begin
          errors++;
          $error("FAIL sb_unexpected observed=0x%0h expected=none", RX);
        end
        if (sb_q.size() > 0) begin
          exp_byte = sb_q.pop_front();
          check("sb_rx_byte", {24'd0, RX}, {24'd0, exp_byte});
        end
        check("stop_pulse_width", {31'd0, prev_stop}, 32'd0);
        check("pulse_exclusive", {31'd0, frame_err}, 32'd0);
      end
      if (frame_err) begin
        n_ferr++;
        check("ferr_pulse_width", {31'd0, prev_ferr}, 32'd0);
      end
      prev_stop = rx_byte_stop;
      prev_ferr = frame_err;
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    n_stop      = 0;
    n_ferr      = 0;
    prev_stop   = 1'b0;
    prev_ferr   = 1'b0;
    rst         = 1'b1;
    rx          = 1'b1;
    data_ready  = 1'b0;
    overrun_clr = 1'b0;
    wait_cycles(5);
    check("reset_RX", {24'd0, RX}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_pulses", {30'd0, rx_byte_stop, frame_err}, 32'd0);
    rst = 1'b0;
    wait_cycles(10);

    // Single byte, downstream not ready
    sb_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    wait_cycles(5);
    check("s1_RX", {24'd0, RX}, 32'h55);
    check("s1_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("s1_n_stop", n_stop, 1);
    check("s1_n_ferr", n_ferr, 0);
    check("s1_overrun", {31'd0, overrun}, 32'd0);
    data_ready = 1'b1;
    wait_cycles(1);
    data_ready = 1'b0;
    check("s1_consumed", {31'd0, rx_valid}, 32'd0);
    check("s1_RX_kept", {24'd0, RX}, 32'h55);

    // Short low glitch on idle line
    rx = 1'b0;
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(2 * CNT);
    check("s2_n_stop", n_stop, 1);
    check("s2_n_ferr", n_ferr, 0);
    check("s2_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("s2_RX", {24'd0, RX}, 32'h55);

    // Bad stop bit, line held low a while before returning high
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(10);
    send_byte(8'hA3, 1'b0);
    rx = 1'b0;
    wait_cycles(3 * CNT);
    check("s3_n_ferr", n_ferr, 1);
    rx = 1'b1;
    wait_cycles(3 * CNT);
    check("s3_n_ferr_after", n_ferr, 1);
    check("s3_n_stop", n_stop, 1);
    check("s3_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("s3_RX", {24'd0, RX}, 32'h00);

    // Back-to-back bytes with no consumer: second byte overruns
    sb_q.push_back(8'h12);
    sb_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    wait_cycles(5);
    check("s4_n_stop", n_stop, 3);
    check("s4_RX", {24'd0, RX}, 32'h12);
    check("s4_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("s4_overrun", {31'd0, overrun}, 32'd1);
    overrun_clr = 1'b1;
    wait_cycles(1);
    overrun_clr = 1'b0;
    check("s4_overrun_clr", {31'd0, overrun}, 32'd0);

    // Consumer always ready, back-to-back stream
    data_ready = 1'b1;
    wait_cycles(2);
    check("s5_drained", {31'd0, rx_valid}, 32'd0);
    sb_q.push_back(8'h00);
    sb_q.push_back(8'hFF);
    sb_q.push_back(8'h81);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h81, 1'b1);
    wait_cycles(5);
    check("s5_n_stop", n_stop, 6);
    check("s5_overrun", {31'd0, overrun}, 32'd0);
    check("s5_RX", {24'd0, RX}, 32'h81);
    data_ready = 1'b0;

    // Reset in the middle of data bit 4, then a clean byte
    bit_period(1'b0);
    for (int i = 0; i < 4; i++) bit_period(i[0]);
    rx = 1'b1;
    wait_cycles(CNT / 2);
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2 * CNT);
    check("s6_abort_n_stop", n_stop, 6);
    check("s6_abort_n_ferr", n_ferr, 1);
    check("s6_abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    sb_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    wait_cycles(5);
    check("s6_n_stop", n_stop, 7);
    check("s6_RX", {24'd0, RX}, 32'h3C);
    check("s6_rx_valid", {31'd0, rx_valid}, 32'd1);
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
